mult_frac_scheduler: RTL

Sequencer for the fracturable 9x9 multiplier (modes 9x9, 2x 4x4, 4x 2x2; signed or unsigned). Accepts a stream of independent multiply requests and packs consecutive same-mode, same-sign requests into the multiplier's lanes. Issues each packed word, registers the product, and unpacks it into an in-order result stream. Sits between an operand producer and one multiplier instance.

---
 rtl/mult_frac_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_frac_scheduler.sv
// Packs same-mode, same-sign multiply requests into the lanes of a fracturable 9x9 multiplier,
// issues the packed word once, registers the product and unpacks it as an in-order result stream.
module mult_frac_scheduler #(
    parameter int unsigned FLUSH_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_a,
    input  logic [8:0]  in_b,
    input  logic [1:0]  in_mode,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_p,
    output logic [1:0]  out_mode,
    output logic        out_last,
    output logic [8:0]  mul_A,
    output logic [8:0]  mul_B,
    output logic        mul_A_sign,
    output logic        mul_B_sign,
    output logic        mul_HALF_0,
    output logic        mul_HALF_1,
    output logic        mul_HALF_2,
    input  logic [17:0] mul_C
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StPack   = 2'd1;
    localparam logic [1:0] StIssue  = 2'd2;
    localparam logic [1:0] StUnpack = 2'd3;

    localparam logic [7:0] TmoLimit = 8'(FLUSH_TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic        sign_q, sign_d;
    logic [8:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [17:0] prod_q, prod_d;

    logic [1:0]  in_mode_n;
    logic        key_match;
    logic        accept;
    logic        is_idle;
    logic        last_lane;
    logic [7:0]  f8;
    logic [3:0]  f4;
    logic [17:0] lane_p;

    function automatic logic [2:0] lane_cap(input logic [1:0] m);
        case (m)
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Drops a right-aligned operand into its lane slot; all other bits stay zero.
    function automatic logic [8:0] place(input logic [8:0] v, input logic [1:0] m,
                                         input logic [1:0] lane);
        logic [8:0] r;
        r = '0;
        case (m)
            2'd1: begin
                if (lane[0]) r[8:5] = v[3:0];
                else         r[3:0] = v[3:0];
            end
            2'd2: begin
                case (lane)
                    2'd0:    r[1:0] = v[1:0];
                    2'd1:    r[3:2] = v[1:0];
                    2'd2:    r[6:5] = v[1:0];
                    default: r[8:7] = v[1:0];
                endcase
            end
            default: r = v;
        endcase
        return r;
    endfunction

    assign in_mode_n = (in_mode == 2'd3) ? 2'd0 : in_mode;
    assign key_match = (in_mode_n == mode_q) && (in_signed == sign_q);
    assign is_idle   = (state_q == StIdle);
    assign in_ready  = is_idle || ((state_q == StPack) && key_match);
    assign accept    = in_valid && in_ready;
    assign last_lane = ({1'b0, lane_q} == (cnt_q - 3'd1));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        tmo_d   = tmo_q;
        prod_d  = prod_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d  = in_mode_n;
                    sign_d  = in_signed;
                    a_d     = place(in_a, in_mode_n, 2'd0);
                    b_d     = place(in_b, in_mode_n, 2'd0);
                    cnt_d   = 3'd1;
                    tmo_d   = '0;
                    state_d = (lane_cap(in_mode_n) == 3'd1) ? StIssue : StPack;
                end
            end
            StPack: begin
                if (accept) begin
                    a_d   = a_q | place(in_a, mode_q, cnt_q[1:0]);
                    b_d   = b_q | place(in_b, mode_q, cnt_q[1:0]);
                    cnt_d = cnt_q + 3'd1;
                    tmo_d = '0;
                    if ((cnt_q + 3'd1) == lane_cap(mode_q)) state_d = StIssue;
                end else if (in_valid) begin
                    // A request with a different key flushes the partial group.
                    tmo_d   = '0;
                    state_d = StIssue;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if ((tmo_q + 8'd1) >= TmoLimit) begin
                        tmo_d   = '0;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                prod_d  = mul_C;
                lane_d  = '0;
                state_d = StUnpack;
            end
            StUnpack: begin
                if (out_ready) begin
                    if (last_lane) begin
                        state_d = StIdle;
                        mode_d  = '0;
                        sign_d  = 1'b0;
                        a_d     = '0;
                        b_d     = '0;
                        cnt_d   = '0;
                        lane_d  = '0;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= '0;
            sign_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            tmo_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            tmo_q   <= tmo_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        f8 = lane_q[0] ? prod_q[17:10] : prod_q[7:0];
        case (lane_q)
            2'd0:    f4 = prod_q[3:0];
            2'd1:    f4 = prod_q[7:4];
            2'd2:    f4 = prod_q[13:10];
            default: f4 = prod_q[17:14];
        endcase
        lane_p = prod_q;
        case (mode_q)
            2'd1:    lane_p = {{10{sign_q & f8[7]}}, f8};
            2'd2:    lane_p = {{14{sign_q & f4[3]}}, f4};
            default: lane_p = prod_q;
        endcase
    end

    assign out_valid  = (state_q == StUnpack);
    assign out_p      = out_valid ? lane_p : 18'd0;
    assign out_mode   = out_valid ? mode_q : 2'd0;
    assign out_last   = out_valid && last_lane;

    assign mul_A      = a_q;
    assign mul_B      = b_q;
    assign mul_A_sign = !is_idle && sign_q;
    assign mul_B_sign = !is_idle && sign_q;
    assign mul_HALF_0 = is_idle || (mode_q == 2'd0);
    assign mul_HALF_1 = !is_idle && (mode_q == 2'd1);
    assign mul_HALF_2 = !is_idle && (mode_q == 2'd2);

endmodule
